tdc_therm_encoder: RTL



---
 rtl/tdc_therm_encoder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/tdc_therm_encoder.sv
// TDC thermometer back end: optional input register, bubble correction, binary encode,
// optional window averaging and a one-entry valid/ready holding register.
module tdc_therm_encoder #(
    parameter int TAPS     = 32,
    parameter int CNT_W    = $clog2(TAPS + 1),
    parameter int AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [TAPS-1:0]  therm_i,
    input  logic             sample_i,
    input  logic             bypass_i,
    input  logic             avg_en_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] code_o,
    output logic             code_valid_o,
    input  logic             code_ready_i,
    output logic             overflow_o,
    output logic             bubble_err_o
);

    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int CW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int WIN   = 1 << AVG_LOG2;

    typedef enum logic {ST_ACC, ST_PASS} state_t;

    logic [TAPS-1:0]  therm_q;
    logic             samp_q;
    logic [TAPS-1:0]  t_sel;
    logic [TAPS+1:0]  t_ext;
    logic [TAPS-1:0]  c;
    logic             strobe;
    logic [CNT_W-1:0] enc_next;
    logic             enc_valid;
    logic [CNT_W-1:0] enc_code;
    state_t           state;
    state_t           mode_sel;
    logic [CW-1:0]    cnt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic             take;
    logic             last;
    logic             res_valid;
    logic [CNT_W-1:0] res_code;

    // Only strobes seen in REG mode are captured, so switching into REG mode cannot replay a sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            therm_q <= '0;
            samp_q  <= 1'b0;
        end else if (clear_i) begin
            samp_q  <= 1'b0;
        end else if (ena) begin
            therm_q <= therm_i;
            samp_q  <= sample_i & bypass_i;
        end
    end

    assign t_sel  = bypass_i ? therm_q : therm_i;
    assign strobe = ena & ~clear_i & (bypass_i ? samp_q : sample_i);
    assign t_ext  = {1'b0, t_sel, 1'b1};

    always_comb begin
        c        = '0;
        enc_next = CNT_W'(TAPS);
        for (int unsigned i = 0; i < TAPS; i++) begin
            c[i] = (t_ext[i] & t_ext[i+1]) | (t_ext[i] & t_ext[i+2]) | (t_ext[i+1] & t_ext[i+2]);
        end
        for (int unsigned i = TAPS; i > 0; i--) begin
            if (!c[i-1]) enc_next = CNT_W'(i - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_valid    <= 1'b0;
            enc_code     <= '0;
            bubble_err_o <= 1'b0;
        end else if (clear_i) begin
            enc_valid    <= 1'b0;
            bubble_err_o <= 1'b0;
        end else if (ena) begin
            enc_valid <= strobe;
            if (strobe) begin
                enc_code <= enc_next;
                if (c != t_sel) bubble_err_o <= 1'b1;
            end
        end
    end

    assign take      = ena & enc_valid;
    assign last      = (cnt == CW'(WIN - 1));
    assign sum       = acc + ACC_W'(enc_code);
    assign res_valid = take & ((state == ST_PASS) | last);
    assign res_code  = (state == ST_PASS) ? enc_code : CNT_W'(sum >> AVG_LOG2);
    assign mode_sel  = (avg_en_i && AVG_LOG2 != 0) ? ST_ACC : ST_PASS;

    // The averaging mode is re-latched only while no window is open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ACC;
            cnt   <= '0;
            acc   <= '0;
        end else if (clear_i) begin
            state <= ST_ACC;
            cnt   <= '0;
            acc   <= '0;
        end else if (ena) begin
            if (take) begin
                if (state == ST_PASS) begin
                    state <= mode_sel;
                end else if (last) begin
                    acc   <= '0;
                    cnt   <= '0;
                    state <= mode_sel;
                end else begin
                    acc <= sum;
                    cnt <= cnt + CW'(1);
                end
            end else if (cnt == '0) begin
                state <= mode_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_o       <= '0;
            code_valid_o <= 1'b0;
            overflow_o   <= 1'b0;
        end else if (clear_i) begin
            code_o       <= '0;
            code_valid_o <= 1'b0;
            overflow_o   <= 1'b0;
        end else if (res_valid) begin
            if (!code_valid_o || code_ready_i) begin
                code_o       <= res_code;
                code_valid_o <= 1'b1;
            end else begin
                overflow_o   <= 1'b1;
            end
        end else if (code_valid_o && code_ready_i) begin
            code_valid_o <= 1'b0;
        end
    end

endmodule
